// File: rtl/mux_rr_reg.sv
// N-channel registered multiplexer with fixed-select or round-robin grant into a one-entry output register.
// Optional channel lock (lock input, sticky grant) is built when MUX_LOCK_EN is defined.
module mux_rr_reg #(
   parameter int DW  = 8,
   parameter int NCH = 8,
   parameter int SW  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef MUX_LOCK_EN
   input  logic              lock,
`endif
   input  logic              mode,
   input  logic [SW-1:0]     select,
   input  logic [NCH-1:0]    in_valid,
   output logic [NCH-1:0]    in_ready,
   input  logic [NCH*DW-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [SW-1:0]     out_chan
);

   logic              out_valid_q;
   logic [DW-1:0]     out_data_q;
   logic [SW-1:0]     out_chan_q;
   logic [SW-1:0]     last_q;

   logic [SW-1:0]     g;
   logic              grant_valid;
   logic              ld;
   logic [DW-1:0]     g_data;

   logic [SW-1:0]     hi_g, lo_g;
   logic              hi_f, lo_f;
   logic              sel_ok;

`ifdef MUX_LOCK_EN
   logic              lock_q;
   logic [SW-1:0]     lock_chan_q;
   logic              lock_valid;
`endif

   // Descending scan so the final hit is the lowest index; channels above last win over the wrap-around set.
   always_comb begin
      hi_g   = '0;
      lo_g   = '0;
      hi_f   = 1'b0;
      lo_f   = 1'b0;
      sel_ok = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            if (SW'(k) > last_q) begin
               hi_g = SW'(k);
               hi_f = 1'b1;
            end else begin
               lo_g = SW'(k);
               lo_f = 1'b1;
            end
         end
         if (SW'(k) == select) sel_ok = in_valid[k];
      end
   end

   always_comb begin
      if (mode) begin
         g           = hi_f ? hi_g : lo_g;
         grant_valid = hi_f | lo_f;
      end else begin
         g           = select;
         grant_valid = sel_ok;
      end
`ifdef MUX_LOCK_EN
      lock_valid = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         if (SW'(k) == lock_chan_q) lock_valid = in_valid[k];
      end
      if (lock_q) begin
         g           = lock_chan_q;
         grant_valid = mode ? lock_valid : (lock_valid && (select == lock_chan_q));
      end
`endif
   end

   assign ld = rst_n && (!out_valid_q || out_ready) && grant_valid;

   always_comb begin
      g_data   = '0;
      in_ready = '0;
      for (int k = 0; k < NCH; k++) begin
         if (SW'(k) == g) begin
            g_data      = in_data[k*DW +: DW];
            in_ready[k] = ld;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         last_q      <= SW'(NCH - 1);
      end else if (ld) begin
         out_valid_q <= 1'b1;
         out_data_q  <= g_data;
         out_chan_q  <= g;
         if (mode) last_q <= g;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef MUX_LOCK_EN
   // While locked, g is always lock_chan_q, so an unlocked transfer from it simply clears the lock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q      <= 1'b0;
         lock_chan_q <= '0;
      end else if (ld) begin
         lock_q <= lock;
         if (lock) lock_chan_q <= g;
      end
   end
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Directed bench for mux_rr_reg: an 8-channel instance plus a 6-channel instance for out-of-range selects.
module tb_mux_rr_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [2:0]  select;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [2:0]  out_chan;
   logic        lock;

   logic [2:0]  sel6;
   logic [5:0]  iv6;
   logic [5:0]  ir6;
   logic [47:0] data6;
   logic        ov6;
   logic        or6;
   logic [7:0]  od6;
   logic [2:0]  oc6;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mux_rr_reg #(.DW(8), .NCH(8), .SW(3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MUX_LOCK_EN
      .lock      (lock),
`endif
      .mode      (mode),
      .select    (select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan)
   );

   mux_rr_reg #(.DW(8), .NCH(6), .SW(3)) u_dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef MUX_LOCK_EN
      .lock      (1'b0),
`endif
      .mode      (mode),
      .select    (sel6),
      .in_valid  (iv6),
      .in_ready  (ir6),
      .in_data   (data6),
      .out_valid (ov6),
      .out_ready (or6),
      .out_data  (od6),
      .out_chan  (oc6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [2:0] ch);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_chan"}, {29'd0, out_chan}, {29'd0, ch});
      chk({tag, "_data"}, {24'd0, out_data}, 32'hA0 + {29'd0, ch});
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b1;
      select    = 3'd0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      lock      = 1'b0;
      sel6      = 3'd0;
      iv6       = 6'h00;
      or6       = 1'b1;
      data6     = {8'h55, 40'h0};
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);

      // reset state, with requests present
      #12;
      chk("rst_in_ready", {24'd0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'h0);
      chk("rst_out_chan", {29'd0, out_chan}, 32'd0);
      in_valid = 8'h00;
      tick();
      rst_n = 1'b1;
      tick();

      // fixed select, channel 5
      mode = 1'b0; select = 3'd5; in_valid = 8'h20;
      #1 chk("sel5_in_ready", {24'd0, in_ready}, 32'h20);
      tick();
      chk_out("sel5", 3'd5);
      in_valid = 8'h00;
      #1 chk("drain_in_ready", {24'd0, in_ready}, 32'h0);
      tick();
      chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

      // select not matching a valid channel
      select = 3'd6; in_valid = 8'h20;
      #1 chk("sel6_in_ready", {24'd0, in_ready}, 32'h0);
      tick();
      chk("sel6_out_valid", {31'd0, out_valid}, 32'd0);

      // select beyond NCH on the 6-channel instance
      sel6 = 3'd7; iv6 = 6'h3F;
      #1 chk("n6_sel7_ready", {26'd0, ir6}, 32'h0);
      tick();
      chk("n6_sel7_valid", {31'd0, ov6}, 32'd0);
      sel6 = 3'd5;
      #1 chk("n6_sel5_ready", {26'd0, ir6}, 32'h20);
      tick();
      chk("n6_sel5_valid", {31'd0, ov6}, 32'd1);
      chk("n6_sel5_chan", {29'd0, oc6}, 32'd5);
      chk("n6_sel5_data", {24'd0, od6}, 32'h55);
      iv6 = 6'h00;

      // round robin, all channels requesting, full throughput
      mode = 1'b1; in_valid = 8'hFF;
      for (int i = 0; i < 10; i++) begin
         #1 chk("rr_in_ready", {24'd0, in_ready}, 32'd1 << (i % 8));
         tick();
         chk_out("rr", 3'(i % 8));
      end

      // reset, then stall with channels 0 and 7 requesting
      in_valid = 8'h00;
      rst_n = 1'b0;
      #1 chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      in_valid = 8'h81; out_ready = 1'b0;
      #1 chk("st_first_ready", {24'd0, in_ready}, 32'h01);
      tick();
      chk_out("st_first", 3'd0);
      #1 chk("st_stall_ready", {24'd0, in_ready}, 32'h0);
      tick();
      chk_out("st_hold1", 3'd0);
      tick();
      chk_out("st_hold2", 3'd0);
      out_ready = 1'b1;
      #1 chk("st_rel_ready", {24'd0, in_ready}, 32'h80);
      tick();
      chk_out("st_rel7", 3'd7);
      tick();
      chk_out("st_rel0", 3'd0);

      // asynchronous reset in the middle of a stall
      out_ready = 1'b0;
      tick();
      chk_out("mid_stall", 3'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_out_chan", {29'd0, out_chan}, 32'd0);
      chk("async_out_data", {24'd0, out_data}, 32'h0);
      chk("async_in_ready", {24'd0, in_ready}, 32'h0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1 chk("post_rst_ready", {24'd0, in_ready}, 32'h01);
      tick();
      chk_out("post_rst", 3'd0);

      // fixed-select transfer does not move the round-robin pointer
      mode = 1'b0; select = 3'd3; in_valid = 8'h08;
      tick();
      chk_out("m0_ch3", 3'd3);
      mode = 1'b1; in_valid = 8'hFF;
      #1 chk("m1_after_ready", {24'd0, in_ready}, 32'h02);
      tick();
      chk_out("m1_after", 3'd1);

`ifdef MUX_LOCK_EN
      in_valid = 8'h0C; lock = 1'b1;
      #1 chk("lk_first_ready", {24'd0, in_ready}, 32'h04);
      tick();
      chk_out("lk_first", 3'd2);
      for (int i = 0; i < 3; i++) begin
         #1 chk("lk_hold_ready", {24'd0, in_ready}, 32'h04);
         tick();
         chk_out("lk_hold", 3'd2);
      end
      mode = 1'b0; select = 3'd3;
      #1 chk("lk_sel3_ready", {24'd0, in_ready}, 32'h0);
      tick();
      chk("lk_sel3_valid", {31'd0, out_valid}, 32'd0);
      mode = 1'b1; lock = 1'b0;
      #1 chk("lk_clear_ready", {24'd0, in_ready}, 32'h04);
      tick();
      chk_out("lk_clear", 3'd2);
      #1 chk("lk_next_ready", {24'd0, in_ready}, 32'h08);
      tick();
      chk_out("lk_next", 3'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
